// File: rtl/tri_frame_buffer_if.sv
// Row stream between the frame buffer and its downstream consumer.
// One row of the bitmap is offered per handshake; a row is taken on any
// rising clock edge where row_valid and row_ready are both high.
//
// Signals:
//   row_valid  producer -> consumer  row_idx/row_data are meaningful
//   row_ready  consumer -> producer  consumer takes the current row
//   row_idx    producer -> consumer  row number (YW bits)
//   row_data   producer -> consumer  bit x = pixel (x, row_idx)
interface tri_frame_buffer_if #(
    parameter int XW = 3,
    parameter int YW = 3
);
    logic                row_valid;
    logic                row_ready;
    logic [YW-1:0]       row_idx;
    logic [(1<<XW)-1:0]  row_data;

    modport master (
        output row_valid,
        output row_idx,
        output row_data,
        input  row_ready
    );

    modport slave (
        input  row_valid,
        input  row_idx,
        input  row_data,
        output row_ready
    );
endinterface

// File: rtl/tri_frame_buffer.sv
// Frame buffer behind the triangle rendering engine.
// It collects the interior points of one triangle into a 2**YW x 2**XW
// one-bit bitmap while the engine is busy. When busy falls, it streams the
// bitmap out one row at a time over the row handshake, then clears itself.
//
// Ports:
//   clk         clock, rising edge
//   reset_n     asynchronous active-low reset
//   busy        engine busy; its rise opens a frame, its fall closes it
//   po, xo, yo  engine point strobe and coordinates
//   rows        row stream (master side): row_valid/row_idx/row_data out,
//               row_ready in
//   frame_done  one-cycle pulse after the last row is taken
//   pix_count   points captured this frame (duplicates included), saturating
//   dup_err     sticky for the frame: a point landed on a pixel already set
//   proto_err   sticky until reset: po or a busy rise arrived when not allowed
//   fb_busy     high whenever a frame is being captured or drained
module tri_frame_buffer #(
    parameter int XW = 3,
    parameter int YW = 3,
    parameter int CW = 7
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  busy,
    input  logic                  po,
    input  logic [XW-1:0]         xo,
    input  logic [YW-1:0]         yo,
    tri_frame_buffer_if.master    rows,
    output logic                  frame_done,
    output logic [CW-1:0]         pix_count,
    output logic                  dup_err,
    output logic                  proto_err,
    output logic                  fb_busy
);
    localparam int GW = 1 << XW;
    localparam int GH = 1 << YW;

    typedef enum logic [1:0] {IDLE, CAPTURE, DUMP} state_t;

    state_t                 state;
    state_t                 state_next;
    logic                   busy_q;
    logic [GH-1:0][GW-1:0]  bitmap;
    logic [YW-1:0]          row_idx;

    logic                   rise;
    logic                   fall;
    logic                   start;
    logic                   capture;
    logic                   accept;
    logic                   last_accept;
    logic                   proto_hit;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + 1'b1;
    endfunction

    assign rise = busy & ~busy_q;
    assign fall = ~busy & busy_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        start       = 1'b0;
        capture     = 1'b0;
        accept      = 1'b0;
        last_accept = 1'b0;
        proto_hit   = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_next = CAPTURE;
                    start      = 1'b1;
                    // A point arriving with the busy rise belongs to the new frame.
                    capture    = po;
                end else if (po) begin
                    proto_hit  = 1'b1;
                end
            end
            CAPTURE: begin
                // The fall cycle still captures its point.
                capture = po;
                if (fall) begin
                    state_next = DUMP;
                end
            end
            DUMP: begin
                proto_hit = po | rise;
                accept    = rows.row_ready;
                if (rows.row_ready && (row_idx == {YW{1'b1}})) begin
                    last_accept = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q     <= 1'b0;
            bitmap     <= '0;
            row_idx    <= '0;
            frame_done <= 1'b0;
            pix_count  <= '0;
            dup_err    <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            busy_q     <= busy;
            frame_done <= last_accept;
            if (proto_hit) begin
                proto_err <= 1'b1;
            end
            // Incrementing past the last row wraps back to 0 for the next frame.
            if (accept) begin
                row_idx <= row_idx + 1'b1;
            end
            if (last_accept) begin
                bitmap <= '0;
            end else if (capture) begin
                bitmap[yo][xo] <= 1'b1;
            end
            // The bitmap is empty on a frame start, so no duplicate is possible there.
            if (start) begin
                pix_count <= {{(CW-1){1'b0}}, capture};
                dup_err   <= 1'b0;
            end else if (capture) begin
                pix_count <= sat_inc(pix_count);
                if (bitmap[yo][xo]) begin
                    dup_err <= 1'b1;
                end
            end
        end
    end

    assign rows.row_valid = (state == DUMP);
    assign rows.row_idx   = row_idx;
    assign rows.row_data  = (state == DUMP) ? bitmap[row_idx] : '0;
    assign fb_busy        = (state != IDLE);
endmodule

// File: tb/tb_tri_frame_buffer.sv
module tb_tri_frame_buffer;
    localparam int XW = 3;
    localparam int YW = 3;
    localparam int CW = 7;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           busy = 1'b0;
    logic           po = 1'b0;
    logic [XW-1:0]  xo = '0;
    logic [YW-1:0]  yo = '0;
    logic           frame_done;
    logic [CW-1:0]  pix_count;
    logic           dup_err;
    logic           proto_err;
    logic           fb_busy;

    tri_frame_buffer_if #(.XW(XW), .YW(YW)) rows ();

    tri_frame_buffer #(.XW(XW), .YW(YW), .CW(CW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .busy       (busy),
        .po         (po),
        .xo         (xo),
        .yo         (yo),
        .rows       (rows),
        .frame_done (frame_done),
        .pix_count  (pix_count),
        .dup_err    (dup_err),
        .proto_err  (proto_err),
        .fb_busy    (fb_busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [YW-1:0] idx;
        logic [7:0]    data;
    } row_t;

    row_t       exp_q[$];
    logic [7:0] img [8];
    bit         ready_mode = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_img();
        for (int i = 0; i < 8; i++) img[i] = 8'h00;
    endtask

    task automatic push_img();
        row_t r;
        for (int i = 0; i < 8; i++) begin
            r.idx  = i[YW-1:0];
            r.data = img[i];
            exp_q.push_back(r);
        end
    endtask

    task automatic point(input int x, input int y);
        po = 1'b1;
        xo = x[XW-1:0];
        yo = y[YW-1:0];
        tick();
        po = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int i;
        for (i = 0; i < 60; i++) begin
            if (!fb_busy && exp_q.size() == 0) break;
            tick();
        end
        if (i == 60) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: drain timeout, %0d rows outstanding", name, exp_q.size());
            exp_q.delete();
        end
        tick();
        tick();
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_row_valid"},  32'(rows.row_valid), 0);
        chk({name, "_row_idx"},    32'(rows.row_idx), 0);
        chk({name, "_row_data"},   32'(rows.row_data), 0);
        chk({name, "_frame_done"}, 32'(frame_done), 0);
        chk({name, "_pix_count"},  32'(pix_count), 0);
        chk({name, "_dup_err"},    32'(dup_err), 0);
        chk({name, "_proto_err"},  32'(proto_err), 0);
        chk({name, "_fb_busy"},    32'(fb_busy), 0);
    endtask

    // Consumer ready: tied high, or the repeating 1,0,0,1 pattern.
    initial begin : ready_drv
        logic [3:0] pat;
        int cyc;
        pat = 4'b1001;
        cyc = 0;
        rows.row_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            rows.row_ready = ready_mode ? pat[cyc % 4] : 1'b1;
        end
    end

    // Scoreboard monitor: pops an expected row on every accepted handshake.
    initial begin : monitor
        row_t          e;
        bit            stall_prev;
        bit            last_prev;
        logic [YW-1:0] idx_prev;
        logic [7:0]    data_prev;
        stall_prev = 1'b0;
        last_prev  = 1'b0;
        idx_prev   = '0;
        data_prev  = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                stall_prev = 1'b0;
                last_prev  = 1'b0;
            end else begin
                if (last_prev || frame_done) chk("frame_done_pulse", 32'(frame_done), 32'(last_prev));
                last_prev = 1'b0;
                if (stall_prev) begin
                    chk("stall_valid", 32'(rows.row_valid), 1);
                    chk("stall_idx",   32'(rows.row_idx), 32'(idx_prev));
                    chk("stall_data",  32'(rows.row_data), 32'(data_prev));
                end
                stall_prev = 1'b0;
                if (rows.row_valid && rows.row_ready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_row: got idx %0d data %0h, expected no row", rows.row_idx, rows.row_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("row_idx",  32'(rows.row_idx), 32'(e.idx));
                        chk("row_data", 32'(rows.row_data), 32'(e.data));
                    end
                    if (rows.row_idx == 3'd7) last_prev = 1'b1;
                end else if (rows.row_valid) begin
                    stall_prev = 1'b1;
                    idx_prev   = rows.row_idx;
                    data_prev  = rows.row_data;
                end
            end
        end
    end

    initial begin : stim
        int i;
        // Reset state
        #2;
        chk_all_zero("reset");
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // 1: three points, ready tied high
        clear_img();
        img[0] = 8'h02;
        img[1] = 8'h06;
        push_img();
        busy = 1'b1;
        tick();
        chk("t1_fb_busy", 32'(fb_busy), 1);
        point(1, 0);
        point(1, 1);
        point(2, 1);
        busy = 1'b0;
        tick();
        chk("t1_row_valid", 32'(rows.row_valid), 1);
        chk("t1_pix_count", 32'(pix_count), 3);
        chk("t1_dup_err",   32'(dup_err), 0);
        wait_drain("t1");
        chk("t1_fb_busy_end", 32'(fb_busy), 0);

        // 2: same frame, stalling consumer
        ready_mode = 1'b1;
        push_img();
        busy = 1'b1;
        tick();
        point(1, 0);
        point(1, 1);
        point(2, 1);
        busy = 1'b0;
        tick();
        wait_drain("t2");
        ready_mode = 1'b0;

        // 3: duplicate point
        clear_img();
        img[7] = 8'h20;
        push_img();
        busy = 1'b1;
        tick();
        point(5, 7);
        point(5, 7);
        busy = 1'b0;
        tick();
        chk("t3_dup_err",   32'(dup_err), 1);
        chk("t3_pix_count", 32'(pix_count), 2);
        wait_drain("t3");
        chk("t3_dup_hold",  32'(dup_err), 1);

        // 4: next frame clears dup_err; point in the fall cycle is captured
        clear_img();
        img[3] = 8'h08;
        push_img();
        busy = 1'b1;
        tick();
        chk("t4_dup_clr", 32'(dup_err), 0);
        chk("t4_pix_clr", 32'(pix_count), 0);
        busy = 1'b0;
        po = 1'b1;
        xo = 3'd3;
        yo = 3'd3;
        tick();
        po = 1'b0;
        chk("t4_pix_count", 32'(pix_count), 1);
        wait_drain("t4");

        // 5: protocol errors in IDLE and DUMP
        chk("t5_proto_before", 32'(proto_err), 0);
        point(6, 6);
        chk("t5_proto_idle", 32'(proto_err), 1);
        chk("t5_idle_busy",  32'(fb_busy), 0);
        clear_img();
        img[0] = 8'h01;
        push_img();
        busy = 1'b1;
        tick();
        point(0, 0);
        busy = 1'b0;
        tick();
        point(7, 7);
        busy = 1'b1;
        tick();
        busy = 1'b0;
        chk("t5_still_dump", 32'(fb_busy), 1);
        chk("t5_pix_hold",   32'(pix_count), 1);
        wait_drain("t5");
        chk("t5_proto_sticky", 32'(proto_err), 1);

        // 6: asynchronous reset mid-DUMP at row 4
        clear_img();
        img[0] = 8'h01;
        img[4] = 8'h44;
        push_img();
        busy = 1'b1;
        tick();
        point(0, 0);
        point(2, 4);
        point(6, 4);
        busy = 1'b0;
        tick();
        for (i = 0; i < 20; i++) begin
            if (rows.row_valid && rows.row_idx == 3'd4) break;
            tick();
        end
        chk("t6_reach_row4", 32'(i < 20), 1);
        reset_n = 1'b0;
        #1;
        chk_all_zero("t6_async");
        exp_q.delete();
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        chk("t6_no_frame_done", 32'(frame_done), 0);
        clear_img();
        img[2] = 8'h02;
        push_img();
        busy = 1'b1;
        tick();
        point(1, 2);
        busy = 1'b0;
        tick();
        wait_drain("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
